// File: rtl/control_if.sv
// Bundle between the IF stage/register file and the decode controller.
// The IF side drives instruction, PC+4 and register reads; the decoder returns fields and controls.
interface control_if;
    logic [31:0] instructionin;
    logic [31:0] delayin;
    logic [31:0] busA;
    logic [31:0] busB;

    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  destreg;
    logic [31:0] imm32;
    logic        regdst;
    logic        alusrc;
    logic        mem2reg;
    logic        regwrite;
    logic        memwrite;
    logic        branch;
    logic        jump;
    logic        jal;
    logic        jar;
    logic        loadext;
    logic [3:0]  aluctrl;
    logic [1:0]  dsize;
    logic [1:0]  fpointout;
    logic        busesequal;
    logic [31:0] branchtarget;
    logic [31:0] jumptarget;
    logic [31:0] qdelay;

    modport master (
        output instructionin, delayin, busA, busB,
        input  rs1, rs2, rd, destreg, imm32, regdst, alusrc, mem2reg, regwrite,
               memwrite, branch, jump, jal, jar, loadext, aluctrl, dsize,
               fpointout, busesequal, branchtarget, jumptarget, qdelay
    );

    modport slave (
        input  instructionin, delayin, busA, busB,
        output rs1, rs2, rd, destreg, imm32, regdst, alusrc, mem2reg, regwrite,
               memwrite, branch, jump, jal, jar, loadext, aluctrl, dsize,
               fpointout, busesequal, branchtarget, jumptarget, qdelay
    );
endinterface

// File: rtl/control.sv
// ID-stage decoder: registers the fetched instruction and PC+4, then decodes
// fields, controls, immediate, branch resolution and branch/jump targets combinationally.
module control (
    input  logic      clk,
    input  logic      rst,
    control_if.slave  bus
);
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_SEQ = 4'd8;
    localparam logic [3:0] ALU_LHI = 4'd14;

    logic [31:0] qinst;
    logic [31:0] qdelay;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qinst  <= '0;
            qdelay <= '0;
        end else begin
            qinst  <= bus.instructionin;
            qdelay <= bus.delayin;
        end
    end

    logic [5:0]  op;
    logic [5:0]  fn;
    logic        extop;
    logic        regdst;
    logic        alusrc;
    logic        mem2reg;
    logic        regwrite;
    logic        memwrite;
    logic        jump;
    logic        jal;
    logic        jar;
    logic        loadext;
    logic [3:0]  aluctrl;
    logic [1:0]  dsize;
    logic [1:0]  fpointout;
    logic        rtype_ok;
    logic [31:0] imm32;
    logic        busesequal;

    assign op = qinst[31:26];
    assign fn = qinst[5:0];

    always_comb begin
        extop     = 1'b1;
        regdst    = 1'b0;
        alusrc    = 1'b0;
        mem2reg   = 1'b0;
        regwrite  = 1'b0;
        memwrite  = 1'b0;
        jump      = 1'b0;
        jal       = 1'b0;
        jar       = 1'b0;
        loadext   = 1'b0;
        aluctrl   = ALU_ADD;
        dsize     = 2'b00;
        fpointout = 2'b00;
        rtype_ok  = 1'b1;
        case (op)
            6'h00: begin
                case (fn)
                    6'h04:        aluctrl = ALU_SLL;
                    6'h06:        aluctrl = ALU_SRL;
                    6'h07:        aluctrl = ALU_SRA;
                    6'h20, 6'h21: aluctrl = ALU_ADD;
                    6'h22, 6'h23: aluctrl = ALU_SUB;
                    6'h24:        aluctrl = ALU_AND;
                    6'h25:        aluctrl = ALU_OR;
                    6'h26:        aluctrl = ALU_XOR;
                    6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D:
                                  aluctrl = ALU_SEQ + {1'b0, fn[2:0]};
                    default:      rtype_ok = 1'b0;
                endcase
                // An unknown function code must look exactly like a NOP.
                if (!rtype_ok) aluctrl = ALU_ADD;
                regdst   = rtype_ok;
                regwrite = rtype_ok;
            end
            6'h02: jump = 1'b1;
            6'h03: begin jump = 1'b1; jal = 1'b1; regwrite = 1'b1; end
            6'h12: begin jump = 1'b1; jar = 1'b1; end
            6'h13: begin jump = 1'b1; jar = 1'b1; jal = 1'b1; regwrite = 1'b1; end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h14, 6'h16, 6'h17,
            6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D: begin
                alusrc   = 1'b1;
                regwrite = 1'b1;
                case (op)
                    6'h08, 6'h09: aluctrl = ALU_ADD;
                    6'h0A, 6'h0B: aluctrl = ALU_SUB;
                    6'h0C:        aluctrl = ALU_AND;
                    6'h0D:        aluctrl = ALU_OR;
                    6'h0E:        aluctrl = ALU_XOR;
                    6'h0F:        aluctrl = ALU_LHI;
                    6'h14:        aluctrl = ALU_SLL;
                    6'h16:        aluctrl = ALU_SRL;
                    6'h17:        aluctrl = ALU_SRA;
                    default:      aluctrl = ALU_SEQ + {1'b0, op[2:0]};
                endcase
                extop = !(op inside {6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E});
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26: begin
                alusrc   = 1'b1;
                mem2reg  = 1'b1;
                regwrite = 1'b1;
                loadext  = (op == 6'h20) || (op == 6'h21);
                if (op == 6'h20 || op == 6'h24) dsize = 2'b10;
                if (op == 6'h21 || op == 6'h25) dsize = 2'b01;
                if (op == 6'h26) fpointout = 2'b01;
            end
            6'h28, 6'h29, 6'h2B, 6'h2E: begin
                alusrc   = 1'b1;
                memwrite = 1'b1;
                if (op == 6'h28) dsize = 2'b10;
                if (op == 6'h29) dsize = 2'b01;
                if (op == 6'h2E) fpointout = 2'b01;
            end
            default: ;
        endcase
    end

    assign imm32      = extop ? {{16{qinst[15]}}, qinst[15:0]} : {16'h0000, qinst[15:0]};
    assign busesequal = (bus.busA == bus.busB);

    assign bus.rs1       = qinst[25:21];
    // BEQZ/BNEZ compare rs1 against r0, so rs2 is forced to zero.
    assign bus.rs2       = (op == 6'h04 || op == 6'h05) ? 5'd0 : qinst[20:16];
    assign bus.rd        = qinst[15:11];
    assign bus.destreg   = jal ? 5'd31 : (regdst ? qinst[15:11] : qinst[20:16]);
    assign bus.imm32     = imm32;
    assign bus.regdst    = regdst;
    assign bus.alusrc    = alusrc;
    assign bus.mem2reg   = mem2reg;
    assign bus.regwrite  = regwrite;
    assign bus.memwrite  = memwrite;
    assign bus.branch    = ((op == 6'h04) && busesequal) || ((op == 6'h05) && !busesequal);
    assign bus.jump      = jump;
    assign bus.jal       = jal;
    assign bus.jar       = jar;
    assign bus.loadext   = loadext;
    assign bus.aluctrl   = aluctrl;
    assign bus.dsize     = dsize;
    assign bus.fpointout = fpointout;
    assign bus.busesequal   = busesequal;
    assign bus.branchtarget = {imm32[31:2], 2'b00} + qdelay;
    assign bus.jumptarget   = {{6{qinst[25]}}, qinst[25:2], 2'b00} + qdelay;
    assign bus.qdelay       = qdelay;
endmodule

// File: tb/tb_control.sv
// Bench for the ID-stage decoder: per-cycle comparison against an opcode-table
// model plus hand-computed literal expectations on key vectors.
module tb_control;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    control_if bus ();
    control dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd, destreg;
        logic [31:0] imm32;
        logic        regdst, alusrc, mem2reg, regwrite, memwrite;
        logic        branch, jump, jal, jar, loadext;
        logic [3:0]  aluctrl;
        logic [1:0]  dsize, fpointout;
        logic        busesequal;
        logic [31:0] branchtarget, jumptarget, qdelay;
    } outs_t;

    function automatic outs_t sample();
        outs_t s;
        s.rs1 = bus.rs1; s.rs2 = bus.rs2; s.rd = bus.rd; s.destreg = bus.destreg;
        s.imm32 = bus.imm32; s.regdst = bus.regdst; s.alusrc = bus.alusrc;
        s.mem2reg = bus.mem2reg; s.regwrite = bus.regwrite; s.memwrite = bus.memwrite;
        s.branch = bus.branch; s.jump = bus.jump; s.jal = bus.jal; s.jar = bus.jar;
        s.loadext = bus.loadext; s.aluctrl = bus.aluctrl; s.dsize = bus.dsize;
        s.fpointout = bus.fpointout; s.busesequal = bus.busesequal;
        s.branchtarget = bus.branchtarget; s.jumptarget = bus.jumptarget; s.qdelay = bus.qdelay;
        return s;
    endfunction

    // Opcode-level model: ALU codes derived arithmetically from the opcode/function tables.
    function automatic outs_t model(input logic [31:0] i, input logic [31:0] d,
                                    input logic [31:0] a, input logic [31:0] b);
        outs_t o;
        int    op, fn, code;
        o  = '0;
        op = int'(i[31:26]);
        fn = int'(i[5:0]);
        o.rs1 = i[25:21];
        o.rd  = i[15:11];
        o.rs2 = (op == 4 || op == 5) ? 5'd0 : i[20:16];
        if (op inside {9, 11, 12, 13, 14}) o.imm32 = {16'h0, i[15:0]};
        else                               o.imm32 = {{16{i[15]}}, i[15:0]};
        o.busesequal   = (a == b);
        o.branch       = (op == 4 && a == b) || (op == 5 && a != b);
        o.branchtarget = (o.imm32 & 32'hFFFF_FFFC) + d;
        o.jumptarget   = ({{6{i[25]}}, i[25:0]} & 32'hFFFF_FFFC) + d;
        o.qdelay       = d;
        code = -1;
        if (op == 0) begin
            if (fn == 4) code = 5;
            else if (fn == 6 || fn == 7) code = fn;
            else if (fn >= 32 && fn <= 35) code = (fn - 32) / 2;
            else if (fn >= 36 && fn <= 38) code = fn - 34;
            else if (fn >= 40 && fn <= 45) code = fn - 32;
            if (code >= 0) begin o.regdst = 1; o.regwrite = 1; end
        end else begin
            if (op >= 8 && op <= 11) code = (op - 8) / 2;
            else if (op >= 12 && op <= 14) code = op - 10;
            else if (op == 15) code = 14;
            else if (op == 20) code = 5;
            else if (op == 22 || op == 23) code = op - 16;
            else if (op >= 24 && op <= 29) code = op - 16;
            if (code >= 0) begin o.alusrc = 1; o.regwrite = 1; end
        end
        if (code >= 0) o.aluctrl = 4'(code);
        if (op inside {32, 33, 35, 36, 37, 38}) begin
            o.alusrc = 1; o.mem2reg = 1; o.regwrite = 1;
            o.loadext = (op == 32 || op == 33);
        end
        if (op inside {40, 41, 43, 46}) begin o.alusrc = 1; o.memwrite = 1; end
        if (op inside {32, 36, 40}) o.dsize = 2'b10;
        if (op inside {33, 37, 41}) o.dsize = 2'b01;
        if (op == 38 || op == 46) o.fpointout = 2'b01;
        if (op inside {2, 3, 18, 19}) begin
            o.jump = 1;
            o.jal  = (op == 3 || op == 19);
            o.jar  = (op == 18 || op == 19);
            o.regwrite = o.jal;
        end
        o.destreg = o.jal ? 5'd31 : (o.regdst ? i[15:11] : i[20:16]);
        return o;
    endfunction

    logic [31:0] m_inst  = '0;
    logic [31:0] m_delay = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_inst  <= '0;
            m_delay <= '0;
        end else begin
            m_inst  <= bus.instructionin;
            m_delay <= bus.delayin;
        end
    end

    always @(negedge clk) begin
        outs_t exp_o, act_o;
        exp_o = model(m_inst, m_delay, bus.busA, bus.busB);
        act_o = sample();
        checks++;
        if (act_o !== exp_o) begin
            failures++;
            $display("FAIL cycle_model t=%0t inst=%h act=%h exp=%h", $time, m_inst, act_o, exp_o);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, expv);
        end
    endtask

    task automatic apply(input logic [31:0] i, input logic [31:0] d,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        #2;
        bus.instructionin = i;
        bus.delayin       = d;
        bus.busA          = a;
        bus.busB          = b;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] vec_inst [16];

    initial begin
        bus.instructionin = 32'h0043_0820;
        bus.delayin       = 32'h0000_1234;
        bus.busA          = 32'h1;
        bus.busB          = 32'h2;
        #1 rst = 1'b1;
        #1;
        chk("reset_async_regwrite", {31'b0, bus.regwrite}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_held_regwrite", {31'b0, bus.regwrite}, 32'h0);
        chk("reset_held_qdelay", bus.qdelay, 32'h0);
        chk("reset_branchtarget", bus.branchtarget, 32'h0);
        chk("reset_aluctrl", {28'b0, bus.aluctrl}, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;

        // First edge after reset loads normally.
        @(posedge clk);
        #1;
        chk("post_reset_load_destreg", {27'b0, bus.destreg}, 32'd1);
        chk("post_reset_load_qdelay", bus.qdelay, 32'h0000_1234);

        apply(32'h1020_0010, 32'h0000_0100, 32'h0, 32'h0);
        chk("beqz_rs2", {27'b0, bus.rs2}, 32'h0);
        chk("beqz_busesequal", {31'b0, bus.busesequal}, 32'h1);
        chk("beqz_taken", {31'b0, bus.branch}, 32'h1);
        chk("beqz_target", bus.branchtarget, 32'h0000_0110);

        apply(32'h1020_0010, 32'h0000_0100, 32'h5, 32'h0);
        chk("beqz_not_taken", {31'b0, bus.branch}, 32'h0);
        apply(32'h1420_0010, 32'h0000_0100, 32'h0, 32'h0);
        chk("bnez_not_taken", {31'b0, bus.branch}, 32'h0);
        apply(32'h1420_0010, 32'h0000_0100, 32'h0, 32'h8000_0000);
        chk("bnez_taken_msb", {31'b0, bus.branch}, 32'h1);

        apply(32'h1020_FFFC, 32'h0000_0000, 32'h0, 32'h0);
        chk("branch_wrap_neg", bus.branchtarget, 32'hFFFF_FFFC);
        apply(32'h1020_FFFC, 32'h0000_0002, 32'h0, 32'h0);
        chk("branch_wrap_sum", bus.branchtarget, 32'hFFFF_FFFE);
        apply(32'h1020_7FFC, 32'hFFFF_FF00, 32'h0, 32'h0);
        chk("branch_wrap_carry", bus.branchtarget, 32'h0000_7EFC);

        apply(32'h0043_0820, 32'h0, 32'h0, 32'h0);
        chk("add_regdst", {31'b0, bus.regdst}, 32'h1);
        chk("add_regwrite", {31'b0, bus.regwrite}, 32'h1);
        chk("add_aluctrl", {28'b0, bus.aluctrl}, 32'h0);
        chk("add_destreg", {27'b0, bus.destreg}, 32'd1);

        apply(32'h8C41_0004, 32'h0, 32'h0, 32'h0);
        chk("lw_alusrc", {31'b0, bus.alusrc}, 32'h1);
        chk("lw_mem2reg", {31'b0, bus.mem2reg}, 32'h1);
        chk("lw_dsize", {30'b0, bus.dsize}, 32'h0);
        chk("lw_destreg", {27'b0, bus.destreg}, 32'd1);

        apply(32'h0C00_0040, 32'h0000_0200, 32'h0, 32'h0);
        chk("jal_jump", {31'b0, bus.jump}, 32'h1);
        chk("jal_jal", {31'b0, bus.jal}, 32'h1);
        chk("jal_destreg", {27'b0, bus.destreg}, 32'd31);
        chk("jal_target", bus.jumptarget, 32'h0000_0240);

        apply(32'h0BFF_FFFC, 32'h0000_0200, 32'h0, 32'h0);
        chk("j_neg_target", bus.jumptarget, 32'h0000_01FC);

        apply(32'h34A1_FFFF, 32'h0, 32'h0, 32'h0);
        chk("ori_imm", bus.imm32, 32'h0000_FFFF);
        chk("ori_aluctrl", {28'b0, bus.aluctrl}, 32'd3);

        apply(32'h20A1_FFFF, 32'h0, 32'h0, 32'h0);
        chk("addi_imm", bus.imm32, 32'hFFFF_FFFF);

        apply(32'h7400_0005, 32'h0, 32'h0, 32'h0);
        chk("sgei_aluctrl", {28'b0, bus.aluctrl}, 32'd13);
        apply(32'h0000_0005, 32'h0, 32'h0, 32'h0);
        chk("rtype_bad_fn_regwrite", {31'b0, bus.regwrite}, 32'h0);
        apply(32'hA441_0000, 32'h0, 32'h0, 32'h0);
        chk("sh_dsize", {30'b0, bus.dsize}, 32'h1);

        vec_inst = '{32'h0043_0807, 32'h0043_082D, 32'h0043_0826, 32'h3C01_8000,
                     32'h2C21_8000, 32'h5821_0003, 32'h8041_FFFF, 32'h9441_0002,
                     32'h9841_0000, 32'hA041_0001, 32'hB841_0008, 32'h4860_0000,
                     32'h4C60_0000, 32'h0400_1234, 32'hFC00_0000, 32'h3841_8001};
        foreach (vec_inst[k]) apply(vec_inst[k], 32'h0000_4000 + 32'(k * 4), 32'(k), 32'h3);

        apply(32'h2022_0005, 32'h0000_0040, 32'h0, 32'h0);
        chk("addi_before_reset", {31'b0, bus.regwrite}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("midcycle_reset_regwrite", {31'b0, bus.regwrite}, 32'h0);
        chk("midcycle_reset_imm", bus.imm32, 32'h0);
        chk("midcycle_reset_qdelay", bus.qdelay, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 Ports SHALL be, in order: clk input 1, posedge clock; rst input 1, asynchronous active-high reset; instructionin input 32, IF-stage instruction; delayin input 32, address after the delay slot (PC+4); busA input 32, register-file read of rs1; busB input 32, register-file read of rs2.
REQ-002 Decoded outputs SHALL be: rs1 output 5; rs2 output 5; rd output 5; destreg output 5; imm32 output 32; regdst output 1; alusrc output 1; mem2reg output 1; regwrite output 1; memwrite output 1; branch output 1 (taken); jump output 1; jal output 1; jar output 1; loadext output 1; aluctrl output 4; dsize output 2; fpointout output 2; busesequal output 1; branchtarget output 32; jumptarget output 32; qdelay output 32.

Function
REQ-003 On posedge clk: qinst <= instructionin; qdelay <= delayin. All decode logic SHALL be combinational from qinst, qdelay, busA and busB, giving 1-cycle latency.
REQ-004 Field decode: op = qinst[31:26]; fn = qinst[5:0]; rs1 = qinst[25:21]; rd = qinst[15:11].
REQ-005 rs2 = qinst[20:16]. Exception: rs2 SHALL be 0 for BEQZ (0x04) and BNEZ (0x05).
REQ-006 extop=1 sign-extends qinst[15:0] into imm32. extop=0 zero-extends it.
REQ-007 extop SHALL be 0 for ADDUI, SUBUI, ANDI, ORI and XORI, and 1 for all other opcodes.
REQ-008 busesequal = (busA == busB), a full 32-bit compare.
REQ-009 branch = (op==0x04 & busesequal) | (op==0x05 & ~busesequal).
REQ-010 branchtarget = {imm32[31:2],2'b00} + qdelay, computed by a 32-bit adder with carry-in 0. Carry-out SHALL be discarded and the sum SHALL wrap modulo 2^32.
REQ-011 jumptarget = {signext(qinst[25:2]),2'b00} + qdelay, wrapping modulo 2^32.
REQ-012 aluctrl codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SEQ, 9 SNE, 10 SLT, 11 SGT, 12 SLE, 13 SGE, 14 LHI.
REQ-013 op 0x00 (R-type): regdst=1, regwrite=1, alusrc=0.
REQ-014 R-type fn mapping: 0x04 SLL; 0x06 SRL; 0x07 SRA; 0x20 and 0x21 ADD; 0x22 and 0x23 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x28 to 0x2D map to SEQ through SGE in order.
REQ-015 ALU immediate ops (regdst=0, alusrc=1, regwrite=1):
- 0x08 and 0x09: ADD; 0x0A and 0x0B: SUB; 0x0C AND; 0x0D OR; 0x0E XOR; 0x0F LHI.
- 0x14 SLL; 0x16 SRL; 0x17 SRA; 0x18 to 0x1D map to SEQ through SGE.
REQ-016 Loads (alusrc=1, mem2reg=1, regwrite=1, aluctrl=ADD):
- 0x20 LB: dsize=10, loadext=1. 0x21 LH: dsize=01, loadext=1. 0x23 LW: dsize=00.
- 0x24 LBU: dsize=10, loadext=0. 0x25 LHU: dsize=01, loadext=0. 0x26 LF: dsize=00, fpointout=01.
REQ-017 Stores (alusrc=1, memwrite=1, aluctrl=ADD): 0x28 SB dsize=10; 0x29 SH dsize=01; 0x2B SW dsize=00; 0x2E SF dsize=00, fpointout=01.
REQ-018 Jumps: 0x02 J sets jump=1.
REQ-019 0x03 JAL sets jump=1, jal=1 and regwrite=1.
REQ-020 0x12 JR sets jump=1 and jar=1.
REQ-021 0x13 JALR sets jump=1, jar=1, jal=1 and regwrite=1.
REQ-022 destreg = 31 when jal=1. Otherwise destreg = rd when regdst=1, else qinst[20:16].
REQ-023 Every output not set by REQ-013 to REQ-021 SHALL be 0, including fpointout=00 and dsize=00.
REQ-024 Any opcode not listed, R-type with an unlisted fn, and op 0x01 SHALL decode as NOP: regwrite, memwrite, branch and jump all 0, with outputs as in REQ-023.

Reset
REQ-025 While rst=1, qinst and qdelay SHALL be 0, asynchronously, independent of clk.
REQ-026 qinst=0 SHALL decode as NOP (REQ-024). After reset: branch=0, jump=0, regwrite=0, memwrite=0, aluctrl=0, branchtarget=0.
REQ-027 On rst deassertion, the first posedge clk SHALL load instructionin and delayin normally.

Verification
REQ-028 Assert rst mid-cycle while 0x20220005 (ADDI) is loaded -> outputs return to NOP values immediately, without waiting for a clock edge.
REQ-029 Load 0x10200010 (BEQZ r1, 0x10), qdelay=0x00000100, busA=busB=0 -> rs2=0, busesequal=1, branch=1, branchtarget=0x00000110.
REQ-030 Same as REQ-029 with busA=5, and also with BNEZ 0x14200010 and busA=busB=0 -> branch=0 in both cases.
REQ-031 BEQZ with imm 0xFFFC, qdelay=0x00000000 -> branchtarget=0xFFFFFFFC, wrapping with no error.
REQ-032 Load 0x00430820 (ADD r1,r2,r3) -> regdst=1, regwrite=1, aluctrl=0, destreg=1.
REQ-033 Load 0x8C410004 (LW) -> alusrc=1, mem2reg=1, dsize=00, destreg=1.
REQ-034 Load 0x0C000040 (JAL), qdelay=0x200 -> jump=1, jal=1, destreg=31, jumptarget=0x240.
REQ-035 Load 0x34A1FFFF (ORI) -> imm32=0x0000FFFF, aluctrl=3.
REQ-036 Load 0x20A1FFFF (ADDI) -> imm32=0xFFFFFFFF.
